// File: rtl/sig_gen_pkg.sv
// ============================================================================
// sig_gen_pkg : shared modes, FSM state type and clog2 helper for comb_sig_gen
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sig_gen_pkg;

   localparam logic [1:0] S_NONE = 2'b00;
   localparam logic [1:0] S1     = 2'b01;
   localparam logic [1:0] S2     = 2'b10;
   localparam logic [1:0] S3     = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   function automatic int sg_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/comb_next.sv
// ============================================================================
// comb_next : next-smaller N-bit word with the same popcount
// Revision  : 1.0
// ============================================================================
`default_nettype none

module comb_next #(
   parameter int N = 8
) (
   input  logic [N-1:0] cur_word,
   output logic [N-1:0] next_word,
   output logic         is_last
);

   always_comb begin
      logic found;
      int   pos;
      int   ones_lo;
      found   = 1'b0;
      pos     = 0;
      ones_lo = 0;
      // Lowest "10" pair; everything beneath it is a run of ones at the LSBs.
      for (int b = 1; b < N; b++) begin
         if (!found && cur_word[b] && !cur_word[b-1]) begin
            found = 1'b1;
            pos   = b;
         end
      end
      for (int i = 0; i < N; i++) begin
         if ((i < pos - 1) && cur_word[i]) ones_lo++;
      end
      next_word = cur_word;
      if (found) begin
         for (int i = 0; i < N; i++) begin
            if (i == pos)
               next_word[i] = 1'b0;
            else if (i == pos - 1)
               next_word[i] = 1'b1;
            else if (i < pos - 1)
               next_word[i] = (i >= pos - 1 - ones_lo);
         end
      end
      is_last = !found;
   end

endmodule

`default_nettype wire

// File: rtl/comb_sig_gen.sv
// ============================================================================
// comb_sig_gen : enumerates k-of-N DSSS words (optionally x one-hot RLSS)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module comb_sig_gen
   import sig_gen_pkg::*;
#(
   parameter int N     = 8,
   parameter int R     = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [1:0]                 spare_struct_type,
   input  logic [sg_clog2(N+1)-1:0]   k_sel,
   input  logic                       out_ready,
   output logic [N-1:0]               dsss,
   output logic [R-1:0]               rlss,
   output logic                       out_valid,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [CNT_W-1:0]           seq_cnt
);

   localparam logic [R-1:0] RLSS_TOP  = {1'b1, {(R-1){1'b0}}};
   localparam logic [R-1:0] RLSS_BIT1 = R'(2);

   state_t           state_q, state_d;
   logic             mode3_q, mode3_d;
   logic [N-1:0]     dsss_q, dsss_d;
   logic [R-1:0]     rlss_q, rlss_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N-1:0]     nxt_word;
   logic             is_last;
   logic [N-1:0]     first_word;
   logic             start_legal;
   logic             fire;

   comb_next #(.N(N)) u_next (
      .cur_word  (dsss_q),
      .next_word (nxt_word),
      .is_last   (is_last)
   );

   always_comb begin
      first_word = '0;
      for (int i = 0; i < N; i++) begin
         if (i >= N - int'(k_sel)) first_word[i] = 1'b1;
      end
   end

   assign start_legal = (spare_struct_type != S_NONE) && (k_sel != '0) && (int'(k_sel) <= N);
   assign fire        = valid_q && out_ready;

   always_comb begin
      state_d = state_q;
      mode3_d = mode3_q;
      dsss_d  = dsss_q;
      rlss_d  = rlss_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (start_legal) begin
                  state_d = ST_RUN;
                  mode3_d = (spare_struct_type == S3);
                  cnt_d   = '0;
                  dsss_d  = first_word;
                  rlss_d  = (spare_struct_type == S3) ? RLSS_TOP : '0;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (fire) begin
               cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
               // RLSS sweeps down to bit 1 before the DSSS word moves on.
               if (mode3_q && (rlss_q > RLSS_BIT1)) begin
                  rlss_d = rlss_q >> 1;
               end else if (is_last) begin
                  state_d = ST_FIN;
                  valid_d = 1'b0;
                  dsss_d  = '0;
                  rlss_d  = '0;
               end else begin
                  dsss_d = nxt_word;
                  rlss_d = mode3_q ? RLSS_TOP : '0;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mode3_q <= 1'b0;
         dsss_q  <= '0;
         rlss_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode3_q <= mode3_d;
         dsss_q  <= dsss_d;
         rlss_q  <= rlss_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dsss      = dsss_q;
   assign rlss      = rlss_q;
   assign out_valid = valid_q;
   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_FIN);
   assign err       = err_q;
   assign seq_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_comb_sig_gen.sv
// ============================================================================
// tb_comb_sig_gen : scoreboard bench for comb_sig_gen (N=8, R=4)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_comb_sig_gen;
   import sig_gen_pkg::*;

   localparam int N     = 8;
   localparam int R     = 4;
   localparam int CNT_W = 16;
   localparam int KW    = sg_clog2(N+1);

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [1:0]       mode;
   logic [KW-1:0]    k_sel;
   logic             out_ready;
   logic [N-1:0]     dsss;
   logic [R-1:0]     rlss;
   logic             out_valid;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] seq_cnt;

   comb_sig_gen #(.N(N), .R(R), .CNT_W(CNT_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .spare_struct_type (mode),
      .k_sel             (k_sel),
      .out_ready         (out_ready),
      .dsss              (dsss),
      .rlss              (rlss),
      .out_valid         (out_valid),
      .busy              (busy),
      .done              (done),
      .err               (err),
      .seq_cnt           (seq_cnt)
   );

   always #5 clk = ~clk;

   int             n_tests   = 0;
   int             n_fail    = 0;
   logic [N+R-1:0] exp_q[$];
   int             exp_total = 0;
   int             acc_cnt   = 0;
   int             done_cnt  = 0;
   logic           done_prev = 1'b0;
   logic [N+R-1:0] popped;

   // Monitor: every presented vector must match the scoreboard head.
   always @(negedge clk) begin
      if (rst) begin
         done_prev = 1'b0;
      end else begin
         if (!out_valid && !busy && !done) acc_cnt = 0;
         if (out_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_vec: got dsss=%h rlss=%b, expected no vector", dsss, rlss);
            end else begin
               if ({dsss, rlss} !== exp_q[0] || seq_cnt !== CNT_W'(acc_cnt)) begin
                  n_fail++;
                  $display("FAIL vector: got dsss=%h rlss=%b seq_cnt=%0d, expected dsss=%h rlss=%b seq_cnt=%0d",
                           dsss, rlss, seq_cnt, exp_q[0][N+R-1:R], exp_q[0][R-1:0], acc_cnt);
               end
               if (out_ready) begin
                  popped = exp_q.pop_front();
                  acc_cnt++;
               end
            end
         end
         if (done) begin
            n_tests++;
            if (exp_q.size() != 0 || seq_cnt !== CNT_W'(exp_total) || done_prev) begin
               n_fail++;
               $display("FAIL done_pulse: got left=%0d seq_cnt=%0d prev_done=%b, expected left=0 seq_cnt=%0d prev_done=0",
                        exp_q.size(), seq_cnt, done_prev, exp_total);
            end
            done_cnt++;
         end
         done_prev = done;
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Reference: all N-bit values in descending order with popcount k.
   task automatic model_load(input int m, input int k);
      logic [N-1:0] w;
      logic [R-1:0] rv;
      exp_q.delete();
      exp_total = 0;
      for (int v = (1 << N) - 1; v >= 0; v--) begin
         w = v[N-1:0];
         if ($countones(w) == k) begin
            if (m == 3) begin
               for (int r = R - 1; r >= 1; r--) begin
                  rv    = '0;
                  rv[r] = 1'b1;
                  exp_q.push_back({w, rv});
                  exp_total++;
               end
            end else begin
               exp_q.push_back({w, {R{1'b0}}});
               exp_total++;
            end
         end
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {32'd0, dsss, rlss, out_valid, busy, done, err, seq_cnt}, 64'd0);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic do_start(input int m, input int k, input bit expect_ok);
      if (expect_ok) model_load(m, k);
      mode  = m[1:0];
      k_sel = KW'(k);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (!expect_ok) begin
         check("rej_err", err, 1);
         check("rej_busy", busy, 0);
         check("rej_valid", out_valid, 0);
         @(posedge clk);
         #1;
         check("err_clear", err, 0);
      end else begin
         check("start_busy", busy, 1);
      end
   endtask

   task automatic wait_done(input int budget, input bit rnd_ready, input bit poke, input bit fin_poke);
      int base;
      bit got;
      base = done_cnt;
      got  = 1'b0;
      for (int i = 0; i < budget; i++) begin
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         start     = poke && (i == 5 || i == 20);
         if (start) begin
            mode  = 2'b11;
            k_sel = KW'(2);
         end
         @(negedge clk);
         #1;
         if (done_cnt != base) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL done_timeout: got no done in %0d cycles, expected done", budget);
         do_reset();
      end else begin
         start = fin_poke;
         mode  = 2'b01;
         k_sel = KW'(N);
         @(posedge clk);
         #1;
         start = 1'b0;
         check("idle_busy", busy, 0);
         check("idle_valid", out_valid, 0);
         check("hold_seq_cnt", seq_cnt, exp_total);
      end
   endtask

   initial begin
      int base;
      int m;
      int k;
      rst       = 1'b1;
      start     = 1'b0;
      mode      = 2'b00;
      k_sel     = '0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      do_start(1, 4, 1'b1);
      wait_done(400, 1'b0, 1'b0, 1'b0);

      do_start(3, 4, 1'b1);
      wait_done(1000, 1'b0, 1'b0, 1'b1);

      // Backpressure on the second vector.
      do_start(1, 4, 1'b1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("bp_dsss", dsss, 8'hE8);
         check("bp_seq_cnt", seq_cnt, 1);
      end
      wait_done(400, 1'b0, 1'b0, 1'b0);

      do_start(0, 4, 1'b0);
      do_start(1, 0, 1'b0);
      do_start(2, 9, 1'b0);

      do_start(1, 8, 1'b1);
      wait_done(20, 1'b0, 1'b0, 1'b0);
      do_start(3, 8, 1'b1);
      wait_done(20, 1'b0, 1'b0, 1'b0);

      // Abort by reset after ten accepted vectors.
      do_start(2, 4, 1'b1);
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("pre_abort_cnt", seq_cnt, 10);
      rst  = 1'b1;
      base = done_cnt;
      @(posedge clk);
      #1;
      check("abort_outputs", {32'd0, dsss, rlss, out_valid, busy, done, err, seq_cnt}, 64'd0);
      rst = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt, base);
      do_start(1, 4, 1'b1);
      wait_done(400, 1'b0, 1'b0, 1'b0);

      do_start(2, 3, 1'b1);
      wait_done(1000, 1'b1, 1'b1, 1'b0);

      for (int t = 0; t < 4; t++) begin
         m = $urandom_range(1, 3);
         k = $urandom_range(1, N);
         do_start(m, k, 1'b1);
         wait_done(3000, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
